// File: rtl/switch_pattern_rx.sv
`default_nettype none
// ============================================================================
//  Module      : switch_pattern_rx
//  Description : Receiver for the switch serial link. Synchronises the line,
//                finds the start bit and samples each bit at mid-bit. It then
//                presents the 4-bit switch pattern in parallel, with valid and
//                frame-error pulses and a count of good frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_pattern_rx #(
  parameter int BIT_CYCLES = 50000,
  parameter int CNT_W      = $clog2(BIT_CYCLES)
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       in,
  output logic [3:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] frame_count
);

  // Sample points. The start bit is checked half a bit in, so every later
  // sample taken one full bit apart lands in the middle of its bit.
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] c_full_last = CNT_W'(BIT_CYCLES - 1);
  localparam logic [1:0]       c_last_idx  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_shreg;
  logic             w_s;
  logic             w_half_hit;
  logic             w_full_hit;

  assign w_s        = r_sync2;
  assign w_half_hit = (r_cnt == c_half_last);
  assign w_full_hit = (r_cnt == c_full_last);

  // The line is asynchronous to sysclk, so it passes through a two-flop synchroniser.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
    end
  end

  // Framing FSM. It also produces the registered one-cycle valid/frame_err pulses.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_shreg     <= 4'd0;
      data        <= 4'd0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_half_hit) begin
            r_cnt <= '0;
            if (w_s) begin
              r_state <= S_DATA;
              r_idx   <= 2'd0;
            end else begin
              // A high pulse shorter than half a bit is treated as line noise.
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_full_hit) begin
            r_cnt          <= '0;
            r_shreg[r_idx] <= w_s;
            if (r_idx == c_last_idx) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (w_full_hit) begin
            r_cnt <= '0;
            if (!w_s) begin
              data        <= r_shreg;
              valid       <= 1'b1;
              frame_count <= frame_count + 8'd1;
              r_state     <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_RECOVER;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RECOVER: begin
          // A line stuck high must not be read as a fresh start bit.
          r_cnt <= '0;
          if (!w_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // r_state is a flop, so busy is a glitch-free decode of it.
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_switch_pattern_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_pattern_rx
//  Description : Self-checking bench for switch_pattern_rx. Frame outcomes
//                are predicted from the frame definition: a low stop bit
//                delivers the pattern and a high stop bit is an error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_pattern_rx;

  localparam int BC = 16;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       in;
  logic [3:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Event counters gathered away from the active edge
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int busy_hi = 0;
  int dbl_pulse = 0;
  int last_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_err = 1'b0;

  // Reference model state
  logic [3:0] exp_data;
  logic [7:0] exp_count;

  always #5 sysclk = ~sysclk;

  switch_pattern_rx #(.BIT_CYCLES(BC)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .in          (in),
    .data        (data),
    .valid       (valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .frame_count (frame_count)
  );

  // Monitor on the falling edge
  always @(negedge sysclk) begin
    cyc = cyc + 1;
    if (valid) begin
      valid_cnt      = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (busy) busy_hi = busy_hi + 1;
    if ((valid && prev_valid) || (frame_err && prev_err)) dbl_pulse = dbl_pulse + 1;
    prev_valid = valid;
    prev_err   = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_data  = 4'd0;
    exp_count = 8'd0;
  endtask

  // Drives one full frame; the line is left low afterwards.
  task automatic send_frame(input logic [3:0] d, input logic stopb);
    in = 1'b1;
    tick(BC);
    for (int i = 0; i < 4; i++) begin
      in = d[i];
      tick(BC);
    end
    in = stopb;
    tick(BC);
    in = 1'b0;
  endtask

  // Frame-level reference: a low stop bit delivers the pattern, a high one is discarded.
  task automatic model_frame(input logic [3:0] d, input logic stopb);
    if (!stopb) begin
      exp_data  = d;
      exp_count = exp_count + 8'd1;
    end
  endtask

  task automatic test_reset();
    int b0, v0, e0;
    in = 1'b0;
    do_reset();
    b0 = busy_hi; v0 = valid_cnt; e0 = err_cnt;
    n_checks++;
    if (data !== 4'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data); end
    n_checks++;
    if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    tick(100);
    n_checks++;
    if (busy_hi != b0 || valid_cnt != v0 || err_cnt != e0) begin
      n_fail++;
      $display("FAIL reset_idle_quiet: busy %0d valid %0d err %0d, expected all 0",
               busy_hi - b0, valid_cnt - v0, err_cnt - e0);
    end
    n_checks++;
    if (data !== 4'd0 || frame_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_hold: data %h count %0d expected 0/0", data, frame_count);
    end
  endtask

  task automatic test_good_frame();
    int v0, start;
    v0 = valid_cnt;
    start = cyc;
    send_frame(4'h5, 1'b0);
    model_frame(4'h5, 1'b0);
    tick(4);
    n_checks++;
    if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL good_valid_cnt: got %0d expected 1", valid_cnt - v0); end
    n_checks++;
    if (data !== exp_data) begin n_fail++; $display("FAIL good_data: got %h expected %h", data, exp_data); end
    n_checks++;
    if (frame_count !== exp_count) begin n_fail++; $display("FAIL good_count: got %0d expected %0d", frame_count, exp_count); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
    n_checks++;
    if (last_valid_cyc - start < 89 || last_valid_cyc - start > 93) begin
      n_fail++; $display("FAIL good_latency: got %0d expected 89..93", last_valid_cyc - start);
    end
  endtask

  task automatic test_glitch();
    int b0, v0, e0;
    b0 = busy_hi; v0 = valid_cnt; e0 = err_cnt;
    in = 1'b1;
    tick(4);
    in = 1'b0;
    tick(24);
    n_checks++;
    if (busy_hi == b0) begin n_fail++; $display("FAIL glitch_busy_seen: got 0 busy cycles expected >0"); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
    n_checks++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      n_fail++; $display("FAIL glitch_pulses: valid %0d err %0d expected 0/0", valid_cnt - v0, err_cnt - e0);
    end
    n_checks++;
    if (data !== exp_data) begin n_fail++; $display("FAIL glitch_data: got %h expected %h", data, exp_data); end
  endtask

  task automatic test_frame_err();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    in = 1'b1;
    tick(BC);
    tick(4 * BC);
    tick(40);
    n_checks++;
    if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL ferr_cnt: got %0d expected 1", err_cnt - e0); end
    n_checks++;
    if (valid_cnt != v0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d expected 0", valid_cnt - v0); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_recover_busy: got %b expected 1", busy); end
    n_checks++;
    if (data !== exp_data || frame_count !== exp_count) begin
      n_fail++; $display("FAIL ferr_data_kept: data %h count %0d expected %h %0d", data, frame_count, exp_data, exp_count);
    end
    in = 1'b0;
    tick(6);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle: got %b expected 0", busy); end
    send_frame(4'hA, 1'b0);
    model_frame(4'hA, 1'b0);
    tick(4);
    n_checks++;
    if (valid_cnt - v0 != 1 || data !== exp_data) begin
      n_fail++; $display("FAIL ferr_next_frame: valid %0d data %h expected 1 %h", valid_cnt - v0, data, exp_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    in = 1'b1;
    tick(BC);
    in = 1'b1;
    tick(BC);
    in = 1'b1;
    tick(8);
    do_reset();
    in = 1'b0;
    tick(2 * BC);
    n_checks++;
    if (valid_cnt != v0 || err_cnt != e0) begin
      n_fail++; $display("FAIL rst_mid_pulses: valid %0d err %0d expected 0/0", valid_cnt - v0, err_cnt - e0);
    end
    n_checks++;
    if (data !== 4'd0 || busy !== 1'b0 || frame_count !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: data %h busy %b count %0d expected 0 0 0", data, busy, frame_count);
    end
    send_frame(4'h3, 1'b0);
    model_frame(4'h3, 1'b0);
    tick(4);
    n_checks++;
    if (data !== exp_data || frame_count !== exp_count) begin
      n_fail++; $display("FAIL rst_mid_next: data %h count %0d expected %h %0d", data, frame_count, exp_data, exp_count);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic       sb;
    int v0, e0, ev, ee;
    v0 = valid_cnt; e0 = err_cnt; ev = 0; ee = 0;
    for (int k = 0; k < 20; k++) begin
      d  = 4'($urandom_range(0, 15));
      sb = ($urandom_range(0, 3) == 0);
      send_frame(d, sb);
      model_frame(d, sb);
      if (sb) ee++; else ev++;
      tick($urandom_range(4, 10));
      n_checks++;
      if (data !== exp_data || frame_count !== exp_count) begin
        n_fail++; $display("FAIL rand_frame%0d: data %h count %0d expected %h %0d", k, data, frame_count, exp_data, exp_count);
      end
    end
    n_checks++;
    if (valid_cnt - v0 != ev || err_cnt - e0 != ee) begin
      n_fail++; $display("FAIL rand_pulses: valid %0d err %0d expected %0d %0d", valid_cnt - v0, err_cnt - e0, ev, ee);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    int v0;
    do_reset();
    tick(4);
    v0 = valid_cnt;
    d = 4'($urandom_range(0, 15));
    for (int k = 0; k < 256; k++) begin
      send_frame(d, 1'b0);
      model_frame(d, 1'b0);
      n_checks++;
      if (data !== exp_data) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", k, data, exp_data); end
      if (k % 2 == 1) tick($urandom_range(0, 3));
      d = d + 4'd1;
    end
    tick(4);
    n_checks++;
    if (valid_cnt - v0 != 256) begin n_fail++; $display("FAIL b2b_valid_cnt: got %0d expected 256", valid_cnt - v0); end
    n_checks++;
    if (frame_count !== 8'd0 || frame_count !== exp_count) begin
      n_fail++; $display("FAIL b2b_wrap: got %0d expected %0d", frame_count, exp_count);
    end
    n_checks++;
    if (dbl_pulse != 0) begin n_fail++; $display("FAIL pulse_width: %0d multi-cycle pulses expected 0", dbl_pulse); end
  endtask

  initial begin
    reset = 1'b1;
    in    = 1'b0;
    exp_data  = 4'd0;
    exp_count = 8'd0;
    tick(1);
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
